hazard_scoreboard: RTL and testbench

Parametrised scoreboard-based hazard unit for the core's decode stage. It replaces fixed-pattern load/mul hazard detection with per-register pending-write tracking. This covers fixed-latency units (countdown) and variable-latency units (atomic unit, divider; cleared by writeback tag). It raises RAW, WAW and structural stalls toward ID and optionally counts stall cycles.

---
 rtl/hazard_scoreboard_if.sv | 38 +++
 rtl/hazard_scoreboard.sv | 114 +++++++++++
 tb/tb_hazard_scoreboard.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID/writeback request and hazard response bundle for hazard_scoreboard
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int RA_W     = 5,
  parameter int FU_W     = 2,
  parameter int CNT_W    = 4
);
  logic                id_valid;
  logic                id_use_rs1;
  logic                id_use_rs2;
  logic [RA_W-1:0]     id_rs1;
  logic [RA_W-1:0]     id_rs2;
  logic [RA_W-1:0]     id_rd;
  logic                id_writes_rd;
  logic [FU_W-1:0]     id_fu;
  logic [CNT_W-1:0]    id_lat;
  logic                flush;
  logic                wb_valid;
  logic [RA_W-1:0]     wb_rd;
  logic [FU_W-1:0]     wb_fu;
  logic                raw_stall;
  logic                waw_stall;
  logic                struct_stall;
  logic                stall;
  logic [NUM_REGS-1:0] busy_vec;

  modport master (
    output id_valid, id_use_rs1, id_use_rs2, id_rs1, id_rs2, id_rd, id_writes_rd,
           id_fu, id_lat, flush, wb_valid, wb_rd, wb_fu,
    input  raw_stall, waw_stall, struct_stall, stall, busy_vec
  );

  modport slave (
    input  id_valid, id_use_rs1, id_use_rs2, id_rs1, id_rs2, id_rd, id_writes_rd,
           id_fu, id_lat, flush, wb_valid, wb_rd, wb_fu,
    output raw_stall, waw_stall, struct_stall, stall, busy_vec
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register pending-write scoreboard raising RAW/WAW/structural stalls to ID
// Optional stall statistics counters enabled by defining HAZARD_STATS_EN.
module hazard_scoreboard #(
  parameter int              NUM_REGS     = 32,
  parameter int              RA_W         = 5,
  parameter int              NUM_FU       = 4,
  parameter int              FU_W         = 2,
  parameter int              CNT_W        = 4,
  parameter logic [NUM_FU-1:0] FU_PIPELINED = 4'b0011
) (
  input  logic                clk,
  input  logic                reset_n,
`ifdef HAZARD_STATS_EN
  output logic [31:0]         stall_cycles,
  output logic [31:0]         raw_cycles,
`endif
  hazard_scoreboard_if.slave  hz
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [FU_W-1:0]     own_q [NUM_REGS];
  logic [FU_W-1:0]     own_d [NUM_REGS];
  logic [NUM_FU-1:0]   occ_q, occ_d;

  logic [NUM_REGS-1:0] fixed_done;
  logic [NUM_REGS-1:0] reg_free;
  logic [NUM_REGS-1:0] eff_busy;
  logic [NUM_FU-1:0]   fu_free;
  logic                raw_c, waw_c, struct_c, stall_c, issue;

  // A writeback only frees its register when the tag still matches the owner.
  always_comb begin
    fixed_done = '0;
    reg_free   = '0;
    fu_free    = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      fixed_done[r] = busy_q[r] && (cnt_q[r] == CNT_W'(1));
      reg_free[r]   = fixed_done[r] ||
                      (busy_q[r] && (cnt_q[r] == '0) && hz.wb_valid &&
                       (hz.wb_rd == RA_W'(r)) && (own_q[r] == hz.wb_fu));
    end
    for (int f = 0; f < NUM_FU; f++) begin
      fu_free[f] = hz.wb_valid && (hz.wb_fu == FU_W'(f));
      for (int r = 0; r < NUM_REGS; r++) begin
        if (fixed_done[r] && (own_q[r] == FU_W'(f))) fu_free[f] = 1'b1;
      end
    end
    eff_busy = busy_q & ~reg_free;
  end

  always_comb begin
    raw_c    = hz.id_valid && ((hz.id_use_rs1 && eff_busy[hz.id_rs1]) ||
                               (hz.id_use_rs2 && eff_busy[hz.id_rs2]));
    waw_c    = hz.id_valid && hz.id_writes_rd && (hz.id_rd != '0) && eff_busy[hz.id_rd];
    struct_c = hz.id_valid && !FU_PIPELINED[hz.id_fu] && occ_q[hz.id_fu] && !fu_free[hz.id_fu];
    stall_c  = raw_c || waw_c || struct_c;
    issue    = hz.id_valid && !stall_c && !hz.flush;
  end

  assign hz.raw_stall    = raw_c;
  assign hz.waw_stall    = waw_c;
  assign hz.struct_stall = struct_c;
  assign hz.stall        = stall_c;
  assign hz.busy_vec     = busy_q;

  // Issue is applied after retirement so a same-cycle reallocation wins.
  always_comb begin
    busy_d = busy_q & ~reg_free;
    occ_d  = occ_q & ~(fu_free & ~FU_PIPELINED);
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (busy_q[r] && (cnt_q[r] > CNT_W'(1))) ? cnt_q[r] - CNT_W'(1) : cnt_q[r];
      own_d[r] = own_q[r];
      if (issue && hz.id_writes_rd && (r != 0) && (hz.id_rd == RA_W'(r))) begin
        busy_d[r] = 1'b1;
        cnt_d[r]  = hz.id_lat;
        own_d[r]  = hz.id_fu;
      end
    end
    if (issue && !FU_PIPELINED[hz.id_fu]) occ_d[hz.id_fu] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      occ_q  <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
        own_q[r] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      occ_q  <= occ_d;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
        own_q[r] <= own_d[r];
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      raw_cycles   <= '0;
    end else begin
      if (stall_c && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
      if (raw_c && (raw_cycles != 32'hFFFF_FFFF))     raw_cycles   <= raw_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] raw_cycles;
`endif

  hazard_scoreboard_if #(.NUM_REGS(32), .RA_W(5), .FU_W(2), .CNT_W(4)) hz_if ();

  hazard_scoreboard #(
    .NUM_REGS(32), .RA_W(5), .NUM_FU(4), .FU_W(2), .CNT_W(4), .FU_PIPELINED(4'b0011)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
`ifdef HAZARD_STATS_EN
    .stall_cycles (stall_cycles),
    .raw_cycles   (raw_cycles),
`endif
    .hz           (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    hz_if.id_valid     = 1'b0;
    hz_if.id_use_rs1   = 1'b0;
    hz_if.id_use_rs2   = 1'b0;
    hz_if.id_rs1       = '0;
    hz_if.id_rs2       = '0;
    hz_if.id_rd        = '0;
    hz_if.id_writes_rd = 1'b0;
    hz_if.id_fu        = '0;
    hz_if.id_lat       = '0;
    hz_if.flush        = 1'b0;
    hz_if.wb_valid     = 1'b0;
    hz_if.wb_rd        = '0;
    hz_if.wb_fu        = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [4:0] rd, input logic [3:0] lat, input logic [1:0] fu);
    hz_if.id_valid     = 1'b1;
    hz_if.id_writes_rd = 1'b1;
    hz_if.id_rd        = rd;
    hz_if.id_lat       = lat;
    hz_if.id_fu        = fu;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    hz_if.id_valid = 1'b1; hz_if.id_use_rs1 = 1'b1; hz_if.id_rs1 = 5'd5;
    #1;
    n_checks++;
    if (hz_if.busy_vec !== 32'h0) begin
      n_fail++; $display("FAIL reset_busy: got %h expected %h", hz_if.busy_vec, 32'h0);
    end
    n_checks++;
    if (hz_if.stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 0", hz_if.stall);
    end
    tick();
    reset_n = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_raw_fixed();
    drive_write(5'd5, 4'd3, 2'd0);
    tick();
    idle();
    hz_if.id_valid = 1'b1; hz_if.id_use_rs1 = 1'b1; hz_if.id_rs1 = 5'd5;
    #1;
    n_checks++;
    if (hz_if.raw_stall !== 1'b1) begin
      n_fail++; $display("FAIL raw_cnt3: got %b expected 1", hz_if.raw_stall);
    end
    tick();
    n_checks++;
    if (hz_if.raw_stall !== 1'b1 || hz_if.busy_vec[5] !== 1'b1) begin
      n_fail++; $display("FAIL raw_cnt2: got raw %b busy %b expected 1 1", hz_if.raw_stall, hz_if.busy_vec[5]);
    end
    tick();
    n_checks++;
    if (hz_if.raw_stall !== 1'b0 || hz_if.stall !== 1'b0) begin
      n_fail++; $display("FAIL raw_cnt1_free: got raw %b stall %b expected 0 0", hz_if.raw_stall, hz_if.stall);
    end
    tick();
    idle();
    n_checks++;
    if (hz_if.busy_vec[5] !== 1'b0) begin
      n_fail++; $display("FAIL raw_busy_clear: got %b expected 0", hz_if.busy_vec[5]);
    end
  endtask

  task automatic test_variable_unit();
    drive_write(5'd7, 4'd0, 2'd2);
    tick();
    idle();
    hz_if.wb_valid = 1'b1; hz_if.wb_rd = 5'd7; hz_if.wb_fu = 2'd3;
    tick();
    idle();
    n_checks++;
    if (hz_if.busy_vec[7] !== 1'b1) begin
      n_fail++; $display("FAIL stale_wb_ignored: got %b expected 1", hz_if.busy_vec[7]);
    end
    drive_write(5'd8, 4'd0, 2'd2);
    #1;
    n_checks++;
    if (hz_if.struct_stall !== 1'b1 || hz_if.stall !== 1'b1) begin
      n_fail++; $display("FAIL struct_occupied: got struct %b stall %b expected 1 1", hz_if.struct_stall, hz_if.stall);
    end
    tick();
    n_checks++;
    if (hz_if.struct_stall !== 1'b1 || hz_if.busy_vec[8] !== 1'b0) begin
      n_fail++; $display("FAIL struct_hold: got struct %b busy8 %b expected 1 0", hz_if.struct_stall, hz_if.busy_vec[8]);
    end
    hz_if.wb_valid = 1'b1; hz_if.wb_rd = 5'd7; hz_if.wb_fu = 2'd2;
    #1;
    n_checks++;
    if (hz_if.struct_stall !== 1'b0 || hz_if.stall !== 1'b0) begin
      n_fail++; $display("FAIL struct_wb_release: got struct %b stall %b expected 0 0", hz_if.struct_stall, hz_if.stall);
    end
    tick();
    idle();
    n_checks++;
    if (hz_if.busy_vec[8:7] !== 2'b10) begin
      n_fail++; $display("FAIL wb_issue_same_cycle: got busy[8:7] %b expected 10", hz_if.busy_vec[8:7]);
    end
    hz_if.id_valid = 1'b1; hz_if.id_fu = 2'd2;
    #1;
    n_checks++;
    if (hz_if.struct_stall !== 1'b1) begin
      n_fail++; $display("FAIL struct_reoccupied: got %b expected 1", hz_if.struct_stall);
    end
    idle();
    hz_if.wb_valid = 1'b1; hz_if.wb_rd = 5'd8; hz_if.wb_fu = 2'd2;
    tick();
    idle();
    n_checks++;
    if (hz_if.busy_vec !== 32'h0) begin
      n_fail++; $display("FAIL var_cleanup: got %h expected %h", hz_if.busy_vec, 32'h0);
    end
  endtask

  task automatic test_rd_zero();
    drive_write(5'd0, 4'd4, 2'd0);
    tick();
    idle();
    n_checks++;
    if (hz_if.busy_vec !== 32'h0) begin
      n_fail++; $display("FAIL rd0_busy: got %h expected %h", hz_if.busy_vec, 32'h0);
    end
    drive_write(5'd0, 4'd2, 2'd0);
    hz_if.id_use_rs1 = 1'b1; hz_if.id_rs1 = 5'd0;
    hz_if.id_use_rs2 = 1'b1; hz_if.id_rs2 = 5'd0;
    #1;
    n_checks++;
    if (hz_if.stall !== 1'b0) begin
      n_fail++; $display("FAIL rd0_stall: got %b expected 0", hz_if.stall);
    end
    tick();
    idle();
  endtask

  task automatic test_waw();
    drive_write(5'd9, 4'd2, 2'd0);
    tick();
    drive_write(5'd9, 4'd3, 2'd0);
    #1;
    n_checks++;
    if (hz_if.waw_stall !== 1'b1 || hz_if.raw_stall !== 1'b0) begin
      n_fail++; $display("FAIL waw_pending: got waw %b raw %b expected 1 0", hz_if.waw_stall, hz_if.raw_stall);
    end
    tick();
    n_checks++;
    if (hz_if.waw_stall !== 1'b0 || hz_if.stall !== 1'b0) begin
      n_fail++; $display("FAIL waw_release: got waw %b stall %b expected 0 0", hz_if.waw_stall, hz_if.stall);
    end
    tick();
    idle();
    tick();
    tick();
    n_checks++;
    if (hz_if.busy_vec[9] !== 1'b1) begin
      n_fail++; $display("FAIL waw_reload: got %b expected 1", hz_if.busy_vec[9]);
    end
    tick();
    n_checks++;
    if (hz_if.busy_vec[9] !== 1'b0) begin
      n_fail++; $display("FAIL waw_done: got %b expected 0", hz_if.busy_vec[9]);
    end
  endtask

  task automatic test_back_to_back();
    drive_write(5'd10, 4'd2, 2'd1);
    tick();
    drive_write(5'd11, 4'd2, 2'd1);
    hz_if.id_use_rs2 = 1'b1; hz_if.id_rs2 = 5'd12;
    #1;
    n_checks++;
    if (hz_if.struct_stall !== 1'b0 || hz_if.stall !== 1'b0) begin
      n_fail++; $display("FAIL pipelined_issue: got struct %b stall %b expected 0 0", hz_if.struct_stall, hz_if.stall);
    end
    tick();
    idle();
    n_checks++;
    if (hz_if.busy_vec[11:10] !== 2'b11) begin
      n_fail++; $display("FAIL b2b_busy: got %b expected 11", hz_if.busy_vec[11:10]);
    end
    hz_if.id_valid = 1'b1; hz_if.id_use_rs2 = 1'b1; hz_if.id_rs2 = 5'd10;
    #1;
    n_checks++;
    if (hz_if.raw_stall !== 1'b0) begin
      n_fail++; $display("FAIL rs2_freeing: got %b expected 0", hz_if.raw_stall);
    end
    hz_if.id_rs2 = 5'd11;
    #1;
    n_checks++;
    if (hz_if.raw_stall !== 1'b1) begin
      n_fail++; $display("FAIL rs2_pending: got %b expected 1", hz_if.raw_stall);
    end
    idle();
    tick();
    tick();
  endtask

  task automatic test_flush_reset();
    drive_write(5'd3, 4'd2, 2'd0);
    hz_if.flush = 1'b1;
    #1;
    n_checks++;
    if (hz_if.stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_stall: got %b expected 0", hz_if.stall);
    end
    tick();
    idle();
    n_checks++;
    if (hz_if.busy_vec[3] !== 1'b0) begin
      n_fail++; $display("FAIL flush_no_issue: got %b expected 0", hz_if.busy_vec[3]);
    end
    drive_write(5'd4, 4'd10, 2'd0);
    tick();
    idle();
    tick();
    n_checks++;
    if (hz_if.busy_vec[4] !== 1'b1) begin
      n_fail++; $display("FAIL countdown_busy: got %b expected 1", hz_if.busy_vec[4]);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (hz_if.busy_vec !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h", hz_if.busy_vec, 32'h0);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_raw_fixed();
    test_variable_unit();
    test_rd_zero();
    test_waw();
    test_back_to_back();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
